// File: rtl/cordic_pkg.sv
// -----------------------------------------------------------------------------
// cordic_pkg
// Shared definitions for the CORDIC vectoring output path.
//   cordic_inf_t  : octant code {sign_x, sign_y, swap} from the pre-stage fold
//   ang_45/90/180 : angle constants for an arbitrary angle width
//   ANG_45/90/180 : the same constants for the default 16-bit angle
//   NBINS         : number of orientation bins over a full turn
// -----------------------------------------------------------------------------
package cordic_pkg;

  typedef struct packed {
    logic sign_x;  // 1 = x was negative
    logic sign_y;  // 1 = y was negative
    logic swap;    // 1 = |y| > |x|, angle was mirrored about 45 degrees
  } cordic_inf_t;

  localparam int CORDIC_AW = 16;
  localparam int NBINS     = 36;

  // Full turn is 2^aw counts.
  function automatic int unsigned ang_45(input int aw);
    return 32'd1 << (aw - 3);
  endfunction

  function automatic int unsigned ang_90(input int aw);
    return 32'd1 << (aw - 2);
  endfunction

  function automatic int unsigned ang_180(input int aw);
    return 32'd1 << (aw - 1);
  endfunction

  localparam int unsigned ANG_45  = 32'd1 << (CORDIC_AW - 3);
  localparam int unsigned ANG_90  = 32'd1 << (CORDIC_AW - 2);
  localparam int unsigned ANG_180 = 32'd1 << (CORDIC_AW - 1);

endpackage

// File: rtl/cordic_inf_fifo.sv
// -----------------------------------------------------------------------------
// cordic_inf_fifo
// Synchronous FIFO carrying octant codes from the pre-stage to the output
// stage. Wrapping read/write pointers plus an occupancy count.
//   clk, rst   : clock, synchronous active-high reset
//   push       : write push_data (dropped when full and not popping)
//   push_data  : octant code to store
//   pop        : consume the head entry
//   pop_data   : head entry, or 000 when empty
//   full       : count == DEPTH
//   ovf_pulse  : push while full without a pop (single-cycle)
//   udf_pulse  : pop while empty (single-cycle)
// -----------------------------------------------------------------------------
module cordic_inf_fifo
  import cordic_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  cordic_inf_t push_data,
  input  logic        pop,
  output cordic_inf_t pop_data,
  output logic        full,
  output logic        ovf_pulse,
  output logic        udf_pulse
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] DEPTH_C = (PW + 1)'(DEPTH);

  cordic_inf_t   mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q, count_d;
  logic          empty, wr_en, rd_en;

  always_comb begin
    empty     = (count_q == '0);
    full      = (count_q == DEPTH_C);
    // A pop frees the head slot in the same cycle, so a full FIFO can
    // still accept a write when it is also being read. An empty FIFO
    // never forwards a same-cycle push: that pop is an underflow.
    rd_en     = pop && !empty;
    wr_en     = push && (!full || pop);
    ovf_pulse = push && full && !pop;
    udf_pulse = pop && empty;
    pop_data  = empty ? cordic_inf_t'(3'b000) : mem_q[rd_ptr_q];
    wr_ptr_d  = wr_en ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d  = rd_en ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d   = count_q + {{PW{1'b0}}, wr_en} - {{PW{1'b0}}, rd_en};
  end

  // Storage needs no reset: pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/cordic_post.sv
// -----------------------------------------------------------------------------
// cordic_post
// Pairs each pre-stage octant code with its CORDIC core result and unfolds
// the first-octant angle to a full-circle angle.
//   clk, rst   : clock, synchronous active-high reset
//   inf_valid  : push octant code inf = {sign_x, sign_y, swap}
//   in_valid   : core result valid; pops one octant code
//   in_ang     : first-octant angle (0 .. 2^(AW-3), larger values saturate)
//   in_mag     : core magnitude, passed through
//   out_valid  : full-circle result valid
//   out_ang    : angle modulo 2^AW
//   out_mag    : delayed in_mag
//   out_bin    : 36-bin orientation index (only with CORDIC_POST_BIN_EN)
//   fifo_full  : octant FIFO full
//   err_ovf    : sticky, push into full FIFO dropped
//   err_udf    : sticky, pop from empty FIFO (code 000 used)
// Optional feature macro: CORDIC_POST_BIN_EN adds a third stage computing
// out_bin and delays out_ang/out_mag by one cycle to stay aligned.
// Latency in_valid -> out_valid: 2 cycles, 3 with CORDIC_POST_BIN_EN.
// -----------------------------------------------------------------------------
module cordic_post
  import cordic_pkg::*;
#(
  parameter int AW    = 16,
  parameter int DW    = 16,
  parameter int DEPTH = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inf_valid,
  input  logic [2:0]    inf,
  input  logic          in_valid,
  input  logic [AW-1:0] in_ang,
  input  logic [DW-1:0] in_mag,
  output logic          out_valid,
  output logic [AW-1:0] out_ang,
  output logic [DW-1:0] out_mag,
`ifdef CORDIC_POST_BIN_EN
  output logic [5:0]    out_bin,
`endif
  output logic          fifo_full,
  output logic          err_ovf,
  output logic          err_udf
);

  // All angle arithmetic is carried in AW+1 bits so 2^AW is representable.
  localparam logic [AW:0] A45  = (AW + 1)'(ang_45(AW));
  localparam logic [AW:0] A90  = (AW + 1)'(ang_90(AW));
  localparam logic [AW:0] A180 = (AW + 1)'(ang_180(AW));
  localparam logic [AW:0] A360 = {1'b1, {AW{1'b0}}};

  cordic_inf_t pop_code;
  logic        ovf_pulse, udf_pulse;

  cordic_inf_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (inf_valid),
    .push_data (cordic_inf_t'(inf)),
    .pop       (in_valid),
    .pop_data  (pop_code),
    .full      (fifo_full),
    .ovf_pulse (ovf_pulse),
    .udf_pulse (udf_pulse)
  );

  // Stage 1: saturate and undo the 45-degree mirror.
  logic          s1_valid_q, s1_valid_d;
  logic [AW:0]   s1_ang_q, s1_ang_d;
  logic          s1_sx_q, s1_sx_d;
  logic          s1_sy_q, s1_sy_d;
  logic [DW-1:0] s1_mag_q, s1_mag_d;
  // Stage 2: quadrant map.
  logic          s2_valid_q, s2_valid_d;
  logic [AW-1:0] s2_ang_q, s2_ang_d;
  logic [DW-1:0] s2_mag_q, s2_mag_d;
  // Sticky error flags.
  logic          err_ovf_q, err_ovf_d;
  logic          err_udf_q, err_udf_d;

  logic [AW:0]   a_sat, a_fold, a_quad;

`ifdef CORDIC_POST_BIN_EN
  logic          s3_valid_q, s3_valid_d;
  logic [AW-1:0] s3_ang_q, s3_ang_d;
  logic [DW-1:0] s3_mag_q, s3_mag_d;
  logic [5:0]    s3_bin_q, s3_bin_d;
  logic [AW+5:0] bin_prod;
`endif

  always_comb begin
    // Stage 1
    a_sat      = ({1'b0, in_ang} > A45) ? A45 : {1'b0, in_ang};
    a_fold     = pop_code.swap ? (A90 - a_sat) : a_sat;
    s1_valid_d = in_valid;
    s1_ang_d   = in_valid ? a_fold          : s1_ang_q;
    s1_sx_d    = in_valid ? pop_code.sign_x : s1_sx_q;
    s1_sy_d    = in_valid ? pop_code.sign_y : s1_sy_q;
    s1_mag_d   = in_valid ? in_mag          : s1_mag_q;

    // Stage 2: reflect into the quadrant given by the signs. The 4th
    // quadrant wraps 2^AW - 0 to 0 through truncation.
    unique case ({s1_sx_q, s1_sy_q})
      2'b00:   a_quad = s1_ang_q;
      2'b10:   a_quad = A180 - s1_ang_q;
      2'b11:   a_quad = A180 + s1_ang_q;
      default: a_quad = A360 - s1_ang_q;
    endcase
    s2_valid_d = s1_valid_q;
    s2_ang_d   = s1_valid_q ? a_quad[AW-1:0] : s2_ang_q;
    s2_mag_d   = s1_valid_q ? s1_mag_q       : s2_mag_q;

    err_ovf_d  = err_ovf_q | ovf_pulse;
    err_udf_d  = err_udf_q | udf_pulse;

`ifdef CORDIC_POST_BIN_EN
    // angle * 36 as (a<<5)+(a<<2); the top 6 bits are the bin index.
    bin_prod   = ({6'b0, s2_ang_q} << 5) + ({6'b0, s2_ang_q} << 2);
    s3_valid_d = s2_valid_q;
    s3_ang_d   = s2_valid_q ? s2_ang_q            : s3_ang_q;
    s3_mag_d   = s2_valid_q ? s2_mag_q            : s3_mag_q;
    s3_bin_d   = s2_valid_q ? bin_prod[AW+5:AW]   : s3_bin_q;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_ang_q   <= '0;
      s1_sx_q    <= 1'b0;
      s1_sy_q    <= 1'b0;
      s1_mag_q   <= '0;
      s2_valid_q <= 1'b0;
      s2_ang_q   <= '0;
      s2_mag_q   <= '0;
      err_ovf_q  <= 1'b0;
      err_udf_q  <= 1'b0;
`ifdef CORDIC_POST_BIN_EN
      s3_valid_q <= 1'b0;
      s3_ang_q   <= '0;
      s3_mag_q   <= '0;
      s3_bin_q   <= '0;
`endif
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_ang_q   <= s1_ang_d;
      s1_sx_q    <= s1_sx_d;
      s1_sy_q    <= s1_sy_d;
      s1_mag_q   <= s1_mag_d;
      s2_valid_q <= s2_valid_d;
      s2_ang_q   <= s2_ang_d;
      s2_mag_q   <= s2_mag_d;
      err_ovf_q  <= err_ovf_d;
      err_udf_q  <= err_udf_d;
`ifdef CORDIC_POST_BIN_EN
      s3_valid_q <= s3_valid_d;
      s3_ang_q   <= s3_ang_d;
      s3_mag_q   <= s3_mag_d;
      s3_bin_q   <= s3_bin_d;
`endif
    end
  end

`ifdef CORDIC_POST_BIN_EN
  assign out_valid = s3_valid_q;
  assign out_ang   = s3_ang_q;
  assign out_mag   = s3_mag_q;
  assign out_bin   = s3_bin_q;
`else
  assign out_valid = s2_valid_q;
  assign out_ang   = s2_ang_q;
  assign out_mag   = s2_mag_q;
`endif

  assign err_ovf = err_ovf_q;
  assign err_udf = err_udf_q;

endmodule

// File: doc/cordic_post.md
# cordic_post

Output-side companion of the CORDIC vectoring path in the feature-orientation unit. The pre-stage folds (x, y) into the first octant and emits a 3-bit octant code `inf` = {sign_x, sign_y, swap}. The CORDIC core then produces a first-octant angle and magnitude several cycles later. This block buffers each `inf` code in order, pairs it with the matching core result, and unfolds the angle to a full-circle value, optionally also emitting a 36-bin orientation index.

## Interface
- `AW`, 16: angle width. Full turn = 2^AW counts; 45° = 2^(AW-3).
- `DW`, 16: magnitude width, passed through unchanged.
- `DEPTH`, 16: `inf` FIFO depth, a power of 2 and at least the core latency + 1.

- `clk` input 1: single clock, rising edge.
- `rst` input 1: synchronous, active-high reset.
- `inf_valid` input 1: push `inf`. Driven from the pre-stage `out_valid`.
- `inf` input 3: {sign_x, sign_y, swap}, where a sign bit of 1 means negative and swap = 1 means |y| > |x|.
- `in_valid` input 1: the core result is valid this cycle.
- `in_ang` input AW: first-octant angle, unsigned, 0..2^(AW-3).
- `in_mag` input DW: core magnitude.
- `out_valid` output 1: full-circle result is valid.
- `out_ang` output AW: angle in 0..2^AW-1, computed modulo 2^AW.
- `out_mag` output DW: delayed copy of `in_mag`.
- `out_bin` output 6: orientation bin 0..35. Present only with `CORDIC_POST_BIN_EN`.
- `fifo_full` output 1: count == DEPTH.
- `err_ovf` output 1: sticky; set when a push arrives while the FIFO is full.
- `err_udf` output 1: sticky; set when a pop arrives while the FIFO is empty.

## Operation
- **FIFO.** The FIFO is DEPTH×3 with wrapping read/write pointers and a count register.
  - A push with a pop in the same cycle is legal, including when the FIFO is full; the count is unchanged.
  - A push while full and not popping drops the write and sets `err_ovf`.
  - A pop while empty sets `err_udf` and uses code 000.
  - There is no empty-FIFO bypass: a simultaneous push stores its entry, and the pop still counts as an underflow.
- **Stage 1** (registered on `in_valid`):
  - Saturation: a = min(`in_ang`, 2^(AW-3)).
  - Fold: if swap, a = 2^(AW-2) − a (90° − a).
  - Latch sign_x and sign_y from the popped entry, and latch `in_mag`.
- **Stage 2**, quadrant map:
  - sign_x=0, sign_y=0 → a
  - sign_x=1, sign_y=0 → 2^(AW-1) − a
  - sign_x=1, sign_y=1 → 2^(AW-1) + a
  - sign_x=0, sign_y=1 → 2^AW − a, modulo 2^AW, so a = 0 gives 0
- **Arithmetic.** All arithmetic is done in AW+1 bits and truncated to AW bits.
- **Streaming.** There is no backpressure. The `in_valid` gaps propagate as `out_valid` gaps.
- **Data outputs.** Data outputs hold their last value when `out_valid` = 0.

## Timing
- `in_valid` to `out_valid` latency is 2 cycles without the macro and 3 cycles with `CORDIC_POST_BIN_EN`.
- Throughput is one result per cycle.
- An `inf` code pushed in cycle t can be popped from cycle t+1 onward.
- On reset, all of the following clear to 0: pointers, count, pipeline valids, `out_ang`, `out_mag`, `out_bin`, `err_ovf`, `err_udf`, `fifo_full`.
- Reset asserted mid-stream discards FIFO contents and in-flight results. `out_valid` is 0 in the cycle after `rst` is sampled high.
- Sticky errors clear only on `rst`.

## Configuration
- **With `CORDIC_POST_BIN_EN` defined:**
  - Stage 3 registers `out_bin` = (`out_ang` × 36) >> AW, computed as (a<<5)+(a<<2) in AW+6 bits.
  - `out_ang` and `out_mag` are delayed one cycle so they stay aligned with `out_bin`.
  - Latency is 3.
- **Without it:** the `out_bin` port and stage 3 are absent, and latency is 2.

## Structure
- **Shared package `cordic_pkg`:**
  - Octant-code typedef `cordic_inf_t` {sign_x, sign_y, swap}.
  - Angle constants ANG_45, ANG_90, ANG_180, derived from AW.
  - Bin-count constant NBINS = 36.
- **Sub-module `cordic_inf_fifo`:** the synchronous 3-bit FIFO carrying count, the full flag and the error pulses. The top level registers the sticky flags.

## Test plan
- **(x=−3, y=4) case.** Push `inf`=101, then after 4 cycles drive `in_ang`=6712, `in_mag`=5. Expect `out_ang`=23096 (126.87°), `out_mag`=5, and `out_bin`=12 with the macro.
- **Wrap boundary.** Push 010, then `in_ang`=0. Expect `out_ang`=0. Push 011, then 0. Expect 49152.
- **Saturation.** Push 000 with `in_ang`=9000. Expect `out_ang`=8192.
- **Ordering.** Push 8 codes back-to-back, then feed 8 core results with gaps. Each output must match its own code in order, and `out_valid` must mirror the gaps at fixed latency.
- **Overflow and underflow.**
  - Fill 16 entries, then push again without a pop. Expect `fifo_full`=1, `err_ovf`=1, and the 17th entry dropped.
  - Push and pop in the same cycle while full. Expect count stays 16 and no error.
  - Pop while empty. Expect `err_udf`=1 and the result computed with code 000.
- **Reset mid-stream.** Assert `rst` with 3 entries queued and 2 results in flight. Next cycle expect `out_valid`=0, count=0, and errors cleared; no stale output after release.
